// File: rtl/system_0_nios2_qsys_0_cpu_debug_ocimem_ctrl.sv
// system_0_nios2_qsys_0_cpu_debug_ocimem_ctrl: JTAG debug access to the OCI RAM, shared with a CPU slave port.
//   clk, reset (async, active high)
//   jdo, take_action_ocimem_a/b, take_no_action_ocimem_a : debug command strobes and payload
//   MonDReg, MonAReg, monitor_ready, monitor_error        : debug results back to the TCK side
//   cpu_address/read/write/writedata, cpu_readdata/readdatavalid/waitrequest : CPU slave port
//   Define OCIMEM_OUTREG_EN to add an output register after the RAM (debug +1, CPU +1 cycle latency).
module system_0_nios2_qsys_0_cpu_debug_ocimem_ctrl #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              cpu_waitrequest
);
  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_PIPE, RD_DATA} state_t;
  (* ram_init_file = INIT_FILE *) logic [31:0] mem [2**ADDR_W];
  state_t            state, state_n;
  logic              busy, cmd_a, cmd_b, cmd_n, rd_cmd, dbg_use, cpu_rd_acc, cpu_wr_acc, wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       wr_data, ram_q, ram_o, cpu_hold;
  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  // strobes are only honoured while idle; a > b > no_action when several collide
  assign busy       = state != IDLE;
  assign cmd_a      = !busy & take_action_ocimem_a;
  assign cmd_b      = !busy & take_action_ocimem_b & !take_action_ocimem_a;
  assign cmd_n      = !busy & take_no_action_ocimem_a & !take_action_ocimem_a & !take_action_ocimem_b;
  assign rd_cmd     = (cmd_a & jdo[34]) | cmd_n;
  // the single RAM port belongs to the debugger on its write cycle and its read-address cycle
  assign dbg_use         = cmd_b | (state == RD_ADDR);
  assign ram_addr        = dbg_use ? MonAReg : cpu_address;
  assign cpu_waitrequest = (cpu_read | cpu_write) & dbg_use;
  assign cpu_rd_acc      = cpu_read & !dbg_use;
  assign cpu_wr_acc      = cpu_write & !dbg_use;
  assign wr_en           = cmd_b | cpu_wr_acc;
  assign wr_data         = cmd_b ? jdo[34:3] : cpu_writedata;
  assign cpu_readdata    = cpu_readdatavalid ? ram_o : cpu_hold;
  always_comb begin
    state_n = IDLE;
    unique case (state)
      IDLE:    state_n = rd_cmd ? RD_ADDR : IDLE;
`ifdef OCIMEM_OUTREG_EN
      RD_ADDR: state_n = RD_PIPE;
`else
      RD_ADDR: state_n = RD_DATA;
`endif
      RD_PIPE: state_n = RD_DATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[ram_addr] <= wr_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      ram_q         <= '0;
      cpu_hold      <= '0;
    end else begin
      state <= state_n;
      ram_q <= mem[ram_addr];
      if (cmd_a) MonAReg <= jdo[ADDR_W+25:26];
      else if (cmd_b | cmd_n) MonAReg <= MonAReg + 1'b1;
      if (busy & (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a)) monitor_error <= 1'b1;
      else if (cmd_a & jdo[35]) monitor_error <= 1'b0;
      if (cmd_a | cmd_n) monitor_ready <= 1'b0;
      else if (state == RD_DATA) monitor_ready <= 1'b1;
      if (state == RD_DATA) MonDReg <= ram_o;
      if (cpu_readdatavalid) cpu_hold <= ram_o;
    end
  end
`ifdef OCIMEM_OUTREG_EN
  logic cpu_rv1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_o             <= '0;
      cpu_rv1           <= 1'b0;
      cpu_readdatavalid <= 1'b0;
    end else begin
      ram_o             <= ram_q;
      cpu_rv1           <= cpu_rd_acc;
      cpu_readdatavalid <= cpu_rv1;
    end
  end
`else
  assign ram_o = ram_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cpu_readdatavalid <= 1'b0;
    else cpu_readdatavalid <= cpu_rd_acc;
  end
`endif
endmodule
